// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared constants for the sequential multiplier controller:
//   - default operand width and slice width
//   - FSM state encodings
//   - helpers that derive the step count and check that WIDTH is a whole
//     number of slices
// ---------------------------------------------------------------------------
package mult_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Number of RUN cycles needed to consume all of A.
    function automatic int steps_f(input int width, input int slice);
        return width / slice;
    endfunction

    // A must split into whole slices, otherwise the top bits would be dropped.
    function automatic bit slice_ok_f(input int width, input int slice);
        return (slice > 0) && ((width % slice) == 0);
    endfunction

endpackage

// File: rtl/mult_slice_pp.sv
// ---------------------------------------------------------------------------
// mult_slice_pp
// Combinational partial-product group for one SLICE-bit slice of A.
// Each set bit of the slice gates a copy of B shifted by its bit position.
// The gated copies are summed, and the sum is shifted into place by
// cnt*SLICE.
//
// Ports:
//   i_b       [WIDTH-1:0]    latched multiplier B
//   i_a_slice [SLICE-1:0]    current slice of latched multiplicand A
//   i_cnt     [CNT_W-1:0]    slice index
//   o_pp      [2*WIDTH-1:0]  shifted partial-product sum for this slice
// ---------------------------------------------------------------------------
module mult_slice_pp #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int CNT_W = 2
) (
    input  logic [WIDTH-1:0]   i_b,
    input  logic [SLICE-1:0]   i_a_slice,
    input  logic [CNT_W-1:0]   i_cnt,
    output logic [2*WIDTH-1:0] o_pp
);

    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_sum;

    assign w_b_ext = {{WIDTH{1'b0}}, i_b};

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < SLICE; j++) begin
            if (i_a_slice[j]) begin
                w_sum = w_sum + (w_b_ext << j);
            end
        end
        o_pp = w_sum << (int'(i_cnt) * SLICE);
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl
// Sequencing controller for the unsigned WIDTH x WIDTH multiplier.
// One operand pair is accepted over a valid/ready handshake. A is then
// consumed SLICE bits per cycle, with each slice's partial-product group
// added into a 2*WIDTH accumulator. The product is held on a valid/ready
// output until it is taken.
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_reset      synchronous active-high reset
//   i_in_valid   operand pair offered
//   o_in_ready   controller can accept operands (IDLE)
//   i_a, i_b     operands, sampled only on acceptance
//   o_out_valid  product available (DONE)
//   i_out_ready  consumer takes product
//   o_p          product A*B, zero unless o_out_valid
//   o_busy       high in RUN or DONE
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for an operand pair, in_ready=1
// RUN     | accumulating one slice of A per cycle, cnt = slice index
// DONE    | product held on o_p with out_valid=1 until out_ready
// ---------------------------------------------------------------------------
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [2*WIDTH-1:0]   o_p,
    output logic                 o_busy
);

    localparam int STEPS = steps_f(WIDTH, SLICE);
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (!slice_ok_f(WIDTH, SLICE)) begin : g_bad_slice
        $error("mult_seq_ctrl: WIDTH must be a non-zero multiple of SLICE");
    end

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;

    logic [SLICE-1:0]   w_a_slice;
    logic [2*WIDTH-1:0] w_pp;

    assign w_a_slice = r_a[int'(r_cnt) * SLICE +: SLICE];

    mult_slice_pp #(
        .WIDTH (WIDTH),
        .SLICE (SLICE),
        .CNT_W (CNT_W)
    ) u_slice_pp (
        .i_b       (r_b),
        .i_a_slice (w_a_slice),
        .i_cnt     (r_cnt),
        .o_pp      (w_pp)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Top bits never carry out: the full sum is exactly A*B.
                    r_acc <= r_acc + w_pp;
                    if (r_cnt == CNT_W'(STEPS - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (i_out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decode from state and are forced low while reset is high.
    assign o_in_ready  = (r_state == ST_IDLE) && !i_reset;
    assign o_out_valid = (r_state == ST_DONE) && !i_reset;
    assign o_busy      = ((r_state == ST_RUN) || (r_state == ST_DONE)) && !i_reset;

    // Partial sums during RUN are never exposed on the product port.
    assign o_p = o_out_valid ? r_acc : '0;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] p;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    mult_seq_ctrl dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_p         (p),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE with out_ready=1: accept, wait for
    // out_valid, check latency and product, then confirm return to IDLE.
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [63:0] exp, input string tag);
        int n;
        out_ready = 1'b1;
        a = op_a;
        b = op_b;
        in_valid = 1'b1;
        check({tag, "_ready_idle"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        a = ~op_a;
        b = ~op_b;
        check({tag, "_ready_run"}, 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd4);
        check({tag, "_p"}, p, exp);
        tick();
        check({tag, "_valid_after"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] expq[$];
        int cyc;
        int last;
        int nacc;
        int nres;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_p", p, 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed products
        run_op(32'd3, 32'd5, 64'd15, "m3x5");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "mmax");
        run_op(32'd0, 32'h1234_5678, 64'd0, "a_zero");
        run_op(32'h8765_4321, 32'd0, 64'd0, "b_zero");
        run_op(32'h8000_0000, 32'd2, 64'h1_0000_0000, "msb_x2");

        // Back-pressure: DONE held for 10 cycles, in_valid pulses ignored
        out_ready = 1'b0;
        a = 32'h0001_0001;
        b = 32'h0000_FFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_p", p, 64'h0000_0000_FFFF_FFFF);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2) == 0;
            a = 32'd5;
            b = 32'd5;
            tick();
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_p", p, 64'h0000_0000_FFFF_FFFF);
            check("bp_hold_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        check("bp_single_busy", 64'(busy), 64'd0);

        // in_valid held with A/B changing through RUN
        a = 32'd6;
        b = 32'd7;
        in_valid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            a = 32'd100 + 32'(i);
            b = 32'd200 + 32'(i);
            check("hold_run_ready", 64'(in_ready), 64'd0);
            check("hold_run_busy", 64'(busy), 64'd1);
            tick();
        end
        check("hold_run_ready_last", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        tick();
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_p", p, 64'd42);
        tick();
        check("hold_idle", 64'(in_ready), 64'd1);

        // Reset on the 2nd RUN cycle
        a = 32'h0000_FFFF;
        b = 32'h0000_FFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("rst_run_ready_forced", 64'(in_ready), 64'd0);
        check("rst_run_busy_forced", 64'(busy), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_run_idle", 64'(in_ready), 64'd1);
        check("rst_run_busy", 64'(busy), 64'd0);
        check("rst_run_p", p, 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst_run_no_valid", 64'(out_valid), 64'd0);
        end
        run_op(32'd7, 32'd9, 64'd63, "m7x9");

        // 20 back-to-back random pairs, in_valid and out_ready tied high
        out_ready = 1'b1;
        in_valid = 1'b1;
        cyc = 0;
        last = 0;
        nacc = 0;
        nres = 0;
        while (nres < 20 && cyc < 400) begin
            if (out_valid) begin
                if (expq.size() > 0) begin
                    check("b2b_p", p, expq.pop_front());
                end else begin
                    check("b2b_unexpected", 64'd1, 64'd0);
                end
                if (nres > 0) check("b2b_spacing", 64'(cyc - last), 64'd6);
                last = cyc;
                nres++;
            end
            if (in_ready) begin
                if (nacc < 20) begin
                    ra = $urandom;
                    rb = $urandom;
                    a = ra;
                    b = rb;
                    expq.push_back(64'(ra) * 64'(rb));
                    nacc++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (nres < 20) begin
                tick();
                cyc++;
            end
        end
        in_valid = 1'b0;
        check("b2b_count", 64'(nres), 64'd20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequencing controller for the 32x32 multiplier. It accepts one operand pair over a valid/ready handshake and iterates over A in SLICE-bit slices. Each slice's partial-product group is summed into a 64-bit accumulator, one slice per cycle, over WIDTH/SLICE cycles. The finished product is presented on a valid/ready output port. The block sits between the key-schedule/round logic that issues multiplies and the shared multiplier datapath, replacing a single-cycle 32-term reduction with a 4-stage time-multiplexed one.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH.
- SLICE, 8, A bits consumed per RUN cycle; WIDTH % SLICE must be 0; STEPS = WIDTH/SLICE (4 at defaults).
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  controller can accept operands.
- A  input  WIDTH  multiplicand, sampled on acceptance only.
- B  input  WIDTH  multiplier, sampled on acceptance only.
- out_valid  output  1  product available.
- out_ready  input  1  consumer takes product.
- P  output  2*WIDTH  unsigned product A*B.
- busy  output  1  high in RUN or DONE.

## Operation
- Unsigned multiply only; no truncation; P = A*B exactly in 2*WIDTH bits.
- State machine has three states, encoded as constants in the package.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a_r=A, b_r=B, acc=0, cnt=0 → RUN.
- RUN:
  - in_ready=0.
  - Each cycle: acc += ({WIDTH'b0, b_r} * a_r[cnt*SLICE +: SLICE]) << (cnt*SLICE); cnt++.
  - Add is 2*WIDTH wide; carry out of bit 2*WIDTH-1 is impossible and is ignored.
  - When cnt==STEPS-1, perform the final add → DONE.
- DONE:
  - out_valid=1; P=acc, held stable.
  - On out_ready → IDLE.
  - in_valid in DONE is ignored (in_ready=0); the input is not latched.
- A and B are don't-care outside the acceptance cycle; changing them during RUN has no effect.
- out_valid must never drop without out_ready, and P must not change while out_valid=1.
- in_ready, out_valid and busy decode directly from state. They are forced 0, 0, 0 while reset is high.

## Timing
- Reset (edge with reset=1): state=IDLE, acc=0, cnt=0, a_r=b_r=0. Outputs: in_ready=0 during reset, 1 on the first cycle after; out_valid=0; busy=0; P=0.
- Reset mid-RUN or mid-DONE: abort; next cycle is IDLE with all registers cleared; no out_valid, no partial result ever visible.
- Latency: acceptance at edge k; RUN edges k+1..k+STEPS; out_valid=1 from the cycle after edge k+STEPS (4 cycles after acceptance at defaults).
- Throughput: with out_ready held 1, one result per STEPS+2 cycles (6 at defaults). This covers accept, 4 RUN, and DONE→IDLE.
- Back-pressure: DONE holds indefinitely; no timeout.
- Simultaneous reset with in_valid or out_ready: reset wins; handshake not completed.

## Structure
- Package mult_pkg:
  - State encoding localparams ST_IDLE/ST_RUN/ST_DONE.
  - Default WIDTH/SLICE.
  - STEPS derivation.
  - Elaboration-time check that WIDTH % SLICE == 0.
- One sub-module, mult_slice_pp: combinational. Inputs b_r, one SLICE-bit slice of A, and cnt. Output is the shifted 2*WIDTH partial-product sum for that slice, built as SLICE gated shifted copies of B summed. This is the same partial-product gating scheme used by the full multiplier.
- Controller: FSM, cnt, a_r/b_r/acc registers, handshake decode.

## Test plan
- A=3, B=5, out_ready=1: in_ready drops after acceptance; out_valid rises exactly 4 cycles later with P=15; IDLE the next cycle.
- A=B=0xFFFFFFFF: P=0xFFFFFFFE00000001; A=0 or B=0: P=0; A=0x80000000, B=2: P=0x100000000.
- out_ready held 0 for 10 cycles in DONE: out_valid stays 1 and P is stable; in_valid pulses in that window are ignored. On release, the result is consumed once, then IDLE.
- in_valid held with changing A/B during RUN: result equals the pair latched at acceptance; in_ready is 0 throughout RUN.
- reset asserted on the 2nd RUN cycle: next cycle IDLE with in_ready=1, out_valid never asserts, P=0. A following 7×9 returns 63.
- 20 back-to-back random pairs with in_valid and out_ready tied 1: each P matches the reference model; results are spaced 6 cycles apart in order.
